// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
//
// Moore-style control FSM for a multicycle MIPS datapath: one shared ALU, a
// unified instruction/data memory, and IR / MDR / ALUOut holding registers.
// Each instruction is split into states. Memory states wait on mem_ready, so
// the same controller works with zero-wait or wait-stated memory.
//
// Ports
//   clk          system clock, rising edge
//   arst_n       asynchronous active-low reset, forces FETCH
//   opcode       IR[31:26], valid from DECODE onward
//   funct        IR[5:0]
//   zero_flag    ALU zero result (combinational from datapath)
//   mem_ready    memory completes the access this cycle
//   iord         memory address select: 0 = PC, 1 = ALUOut
//   mem_write    memory write strobe
//   ir_write     IR load enable
//   pc_en        PC load enable = pc_write | (branch & zero_flag)
//   reg_write    register file write enable
//   reg_dest     write register select: 0 = rt, 1 = rd
//   mem_to_reg   write-back data select: 0 = ALUOut, 1 = MDR
//   alu_src_a    ALU A select: 0 = PC, 1 = rs
//   alu_src_b    ALU B select: 00 rt, 01 const 4, 10 signext imm, 11 imm<<2
//   pc_src       next PC select: 00 ALU result, 01 ALUOut, 10 jump target
//   alu_control  010 add, 110 sub, 000 and, 001 or, 111 slt
//   illegal_op   one-cycle flag for an unsupported opcode or funct
//   state        current state encoding (debug)

module mips_multicycle_control (
  input  logic       clk,
  input  logic       arst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_en,
  output logic       reg_write,
  output logic       reg_dest,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state_reg;
  state_t     state_next;
  logic [1:0] alu_op;
  logic       pc_write;
  logic       branch;
  logic [2:0] funct_alu;
  logic       funct_legal;
  logic       opcode_legal;

  assign state = state_reg;

  // ---------------------------------------------------------------------
  // Instruction field decode
  // ---------------------------------------------------------------------
  assign opcode_legal = opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};

  always_comb begin
    funct_alu   = ALU_ADD;
    funct_legal = 1'b0;
    case (funct)
      6'b100000: begin funct_alu = ALU_ADD; funct_legal = 1'b1; end
      6'b100010: begin funct_alu = ALU_SUB; funct_legal = 1'b1; end
      6'b100100: begin funct_alu = ALU_AND; funct_legal = 1'b1; end
      6'b100101: begin funct_alu = ALU_OR;  funct_legal = 1'b1; end
      6'b101010: begin funct_alu = ALU_SLT; funct_legal = 1'b1; end
      default:   ;
    endcase
  end

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      // Only lw/sw reach MEMADR, so anything that is not sw is treated as lw.
      S_MEMADR: state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_next = funct_legal ? S_ALUWB : S_FETCH;
      S_ALUWB:  state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_ADDIEX: state_next = S_ADDIWB;
      S_ADDIWB: state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------
  always_comb begin
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dest   = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_op     = ALUOP_ADD;
    pc_write   = 1'b0;
    branch     = 1'b0;
    illegal_op = 1'b0;
    case (state_reg)
      S_FETCH: begin
        // PC+4 is computed every FETCH cycle but only committed with the IR
        // load once memory returns the instruction.
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b  = 2'b11;
        illegal_op = ~opcode_legal;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        iord = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_FUNCT;
        illegal_op = ~funct_legal;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dest  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_FUNCT: alu_control = funct_alu;
      default:     alu_control = ALU_ADD;
    endcase
  end

  assign pc_en = pc_write | (branch & zero_flag);

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Moore-style control FSM that sequences a multicycle MIPS datapath: one shared ALU and one unified instruction/data memory, with separate IR, MDR and ALUOut registers. Every datapath control signal comes from the current state, the opcode and funct fields, and the ALU zero flag. A `mem_ready` handshake stretches memory states so the same block works with single-cycle or wait-stated memory. It replaces the divided-clock sequencing of the single-cycle datapath with one clock and explicit states.

## Interface
- No parameters; opcode/funct widths are fixed by the ISA.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `arst_n`  in  1  reset, asynchronous assert, active-low; forces state FETCH.
- `opcode`  in  6  IR[31:26], valid from DECODE onward.
- `funct`  in  6  IR[5:0].
- `zero_flag`  in  1  ALU zero result, combinational from the datapath.
- `mem_ready`  in  1  memory completes the access this cycle.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_write`  out  1  memory write strobe.
- `ir_write`  out  1  IR load enable.
- `pc_en`  out  1  PC load enable; equals pc_write OR (branch AND zero_flag).
- `reg_write`  out  1  register file write enable.
- `reg_dest`  out  1  write-register select: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  write-back data select: 0 = ALUOut, 1 = MDR.
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = rs data.
- `alu_src_b`  out  2  ALU B select: 00 = rt data, 01 = 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- `pc_src`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_control`  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal_op`  out  1  high for one cycle on an unsupported opcode or funct.
- `state`  out  4  current state encoding, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12–15 return to FETCH on the next edge with all outputs at default.
- Default for every output is 0, except `alu_control` = 010.
- Internal alu_op: 00 = add, 01 = sub, 10 = decode from funct.
- funct decode: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111. Any other funct gives 010 and is illegal.

Per-state outputs:
- FETCH: `alu_src_b`=01, alu_op 00.
  - `ir_write` and internal pc_write = `mem_ready`.
  - Advance to DECODE when `mem_ready`=1, otherwise stay.
- DECODE: `alu_src_b`=11, alu_op 00 (precomputes branch target). Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → EXEC
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JUMP
  - anything else → FETCH with `illegal_op`=1
- MEMADR: `alu_src_a`=1, `alu_src_b`=10. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: `iord`=1. Stay until `mem_ready`, then MEMWB.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dest`=0. Then FETCH.
- MEMWR: `iord`=1, `mem_write`=1, held steady while waiting. Stay until `mem_ready`, then FETCH.
- EXEC: `alu_src_a`=1, `alu_src_b`=00, alu_op 10.
  - Legal funct → ALUWB.
  - Illegal funct → FETCH with `illegal_op`=1; no write-back occurs.
- ALUWB: `reg_write`=1, `reg_dest`=1. Then FETCH.
- BRANCH: `alu_src_a`=1, alu_op 01, `pc_src`=01, internal branch=1. Then FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10. Then ADDIWB.
- ADDIWB: `reg_write`=1, `reg_dest`=0. Then FETCH.
- JUMP: `pc_src`=10, pc_write=1. Then FETCH.

## Timing
- State register and all outputs derived from it are Moore outputs.
- Only these are combinational from inputs within the cycle:
  - `pc_en`, from zero_flag in BRANCH.
  - `ir_write` and pc_write, from mem_ready in FETCH.
  - `alu_control` and `illegal_op`, from funct/opcode.
- During and immediately after reset, the state is FETCH and outputs are:
  - `alu_src_b`=01, `alu_control`=010, `state`=0.
  - `ir_write` = `pc_en` = `mem_ready`.
  - All other outputs 0.
- Reset asserted mid-instruction returns the FSM to FETCH immediately. No further `reg_write` or `mem_write` occurs after `arst_n` falls.
- Minimum cycle counts with zero wait states:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Illegal opcode 2; illegal funct 3.
- Each low-`mem_ready` cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. No outputs change during the wait.

## Test plan
- Reset with `mem_ready`=1: `state`=0, `ir_write`=1, `pc_en`=1, `alu_src_b`=01. One edge later, `state`=1.
- lw (opcode 100011), `mem_ready` held at 1: state sequence 0,1,2,3,4,0. `reg_write`=1 and `mem_to_reg`=1 only in state 4.
- sw with `mem_ready` low for 3 cycles in MEMWR: `mem_write`=1 for 4 consecutive cycles, then `state`=0.
- R-type with funct 101010: `alu_control`=111 in EXEC, then ALUWB with `reg_dest`=1. With funct 000111: `illegal_op`=1 and the next state is 0, with no `reg_write`.
- beq in BRANCH: `zero_flag`=1 gives `pc_en`=1 and `pc_src`=01. `zero_flag`=0 gives `pc_en`=0. The next state is 0 in both cases.
- `arst_n` pulsed low in state 7 (ALUWB): `reg_write` drops at once and `state`=0 asynchronously. Opcode 111111 in DECODE gives `illegal_op`=1, then FETCH.
